// File: rtl/prbs_burst_ctrl.sv
// prbs_burst_ctrl
// Burst sequencer for the PRBS generator datapath. It takes one command over a
// valid/ready handshake, seeds the LFSR core once, then steps the core for a
// programmed number of bits per burst. Bursts are separated by programmed idle
// gaps and repeated a programmed number of times.
//
// Optional feature: define PRBS_ERR_INJECT_EN to add err_inject/err_pos. When
// err_inject is high at command acceptance, the tx bit at in-burst index err_pos
// of burst 0 is inverted. Without the macro those ports do not exist and tx_bit
// is the unmodified core bit.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   cmd_valid/ready command handshake; cmd_ready is high only in IDLE
//   cmd_seed        LFSR seed (0 is replaced by 1)
//   cmd_burst_len   bits per burst, 0 means 2^LEN_W
//   cmd_gap_len     idle cycles between bursts, 0 means back-to-back
//   cmd_repeat      extra bursts after the first
//   abort           terminate the running command
//   prbs_load/seed  one-cycle load strobe and seed for the LFSR core
//   prbs_en         core step strobe
//   prbs_bit        core serial output, valid the cycle after prbs_en
//   tx_bit/tx_valid gated serial bit to pins, one cycle after prbs_en
//   busy            command in progress
//   done/aborted    one-cycle completion / abort pulses
//   burst_idx       0-based index of the current burst
module prbs_burst_ctrl #(
  parameter int SEED_W = 7,
  parameter int LEN_W  = 8,
  parameter int RPT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [SEED_W-1:0] cmd_seed,
  input  logic [LEN_W-1:0]  cmd_burst_len,
  input  logic [LEN_W-1:0]  cmd_gap_len,
  input  logic [RPT_W-1:0]  cmd_repeat,
  input  logic              abort,
`ifdef PRBS_ERR_INJECT_EN
  input  logic              err_inject,
  input  logic [LEN_W-1:0]  err_pos,
`endif
  output logic              prbs_load,
  output logic [SEED_W-1:0] prbs_seed,
  output logic              prbs_en,
  input  logic              prbs_bit,
  output logic              tx_bit,
  output logic              tx_valid,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [RPT_W-1:0]  burst_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [LEN_W:0] CNT_ONE = (LEN_W+1)'(1);

  state_t state_q, state_d;

  logic [LEN_W-1:0] blen_q;
  logic [LEN_W-1:0] glen_q;
  logic [RPT_W-1:0] rpt_q;
  logic [LEN_W:0]   bit_cnt;
  logic [LEN_W:0]   gap_cnt;
  logic [LEN_W:0]   burst_total;
  logic             last_bit;
  logic             last_gap;
  logic             last_burst;
  logic             accept;
  logic             abort_hit;

  // A programmed length of 0 stands for the full 2^LEN_W, which is why the
  // counters carry one extra bit.
  assign burst_total = (blen_q == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, blen_q};
  assign last_bit    = (bit_cnt == burst_total - CNT_ONE);
  assign last_gap    = (gap_cnt == {1'b0, glen_q} - CNT_ONE);
  assign last_burst  = (burst_idx == rpt_q);
  assign accept      = cmd_valid && (state_q == S_IDLE);

  // Abort only counts while a command is actively sequencing; in DONE the FSM
  // is already leaving with done asserted, so abort is ignored there.
  assign abort_hit   = abort && (state_q inside {S_LOAD, S_RUN, S_GAP});

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and strobe decode; abort overrides every transition.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    prbs_load = 1'b0;
    prbs_en   = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_d = S_LOAD;
      end
      S_LOAD: begin
        prbs_load = 1'b1;
        state_d   = S_RUN;
      end
      S_RUN: begin
        prbs_en = 1'b1;
        if (last_bit) begin
          if (last_burst)          state_d = S_DONE;
          else if (glen_q == '0)   state_d = S_RUN;
          else                     state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (last_gap) state_d = S_RUN;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_hit) state_d = S_IDLE;
  end

  // Command latch, bit/gap counters, burst index and output pipeline.
  // Counters are cleared at acceptance so they start fresh in LOAD; the seed
  // stays loaded across bursts so the sequence continues between them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blen_q    <= '0;
      glen_q    <= '0;
      rpt_q     <= '0;
      prbs_seed <= SEED_W'(1);
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      burst_idx <= '0;
      tx_valid  <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      tx_valid <= prbs_en;
      aborted  <= abort_hit;
      if (accept) begin
        blen_q    <= cmd_burst_len;
        glen_q    <= cmd_gap_len;
        rpt_q     <= cmd_repeat;
        prbs_seed <= (cmd_seed == '0) ? SEED_W'(1) : cmd_seed;
        bit_cnt   <= '0;
        gap_cnt   <= '0;
        burst_idx <= '0;
      end
      if (state_q == S_RUN) begin
        if (last_bit) begin
          bit_cnt <= '0;
          if (!last_burst) burst_idx <= burst_idx + RPT_W'(1);
        end else begin
          bit_cnt <= bit_cnt + CNT_ONE;
        end
      end
      if (state_q == S_GAP) begin
        gap_cnt <= last_gap ? '0 : gap_cnt + CNT_ONE;
      end
    end
  end

`ifdef PRBS_ERR_INJECT_EN
  logic             err_en_q;
  logic [LEN_W-1:0] err_pos_q;
  logic             flip_q;

  // The flip flag is computed alongside the prbs_en cycle that produces the
  // bit, so it lines up with that bit one cycle later on tx_bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_en_q  <= 1'b0;
      err_pos_q <= '0;
      flip_q    <= 1'b0;
    end else begin
      if (accept) begin
        err_en_q  <= err_inject;
        err_pos_q <= err_pos;
      end
      flip_q <= prbs_en && err_en_q && (burst_idx == '0) &&
                (bit_cnt == {1'b0, err_pos_q});
    end
  end

  assign tx_bit = tx_valid & (prbs_bit ^ flip_q);
`else
  assign tx_bit = tx_valid & prbs_bit;
`endif

endmodule

// File: tb/tb_prbs_burst_ctrl.sv
// tb_prbs_burst_ctrl
// Bench for prbs_burst_ctrl. A small PRBS7 core model drives prbs_bit; a
// schedule model expands each accepted command into the expected per-cycle
// strobes and tx bits, and a compare process checks the DUT every cycle.
// Directed tests add hand-computed literal expectations.
module tb_prbs_burst_ctrl;

  localparam int SEED_W = 7;
  localparam int LEN_W  = 8;
  localparam int RPT_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              abort = 1'b0;
  logic [SEED_W-1:0] cmd_seed = '0;
  logic [LEN_W-1:0]  cmd_burst_len = '0;
  logic [LEN_W-1:0]  cmd_gap_len = '0;
  logic [RPT_W-1:0]  cmd_repeat = '0;
  logic              cmd_ready, prbs_load, prbs_en, tx_bit, tx_valid;
  logic              busy, done, aborted;
  logic [SEED_W-1:0] prbs_seed;
  logic [RPT_W-1:0]  burst_idx;
  logic              prbs_bit = 1'b0;
  logic [SEED_W-1:0] core = 7'h01;
`ifdef PRBS_ERR_INJECT_EN
  logic              err_inject = 1'b0;
  logic [LEN_W-1:0]  err_pos = '0;
`endif

  always #5 clk = ~clk;

  prbs_burst_ctrl #(.SEED_W(SEED_W), .LEN_W(LEN_W), .RPT_W(RPT_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_seed(cmd_seed), .cmd_burst_len(cmd_burst_len),
    .cmd_gap_len(cmd_gap_len), .cmd_repeat(cmd_repeat),
    .abort(abort),
`ifdef PRBS_ERR_INJECT_EN
    .err_inject(err_inject), .err_pos(err_pos),
`endif
    .prbs_load(prbs_load), .prbs_seed(prbs_seed), .prbs_en(prbs_en),
    .prbs_bit(prbs_bit), .tx_bit(tx_bit), .tx_valid(tx_valid),
    .busy(busy), .done(done), .aborted(aborted), .burst_idx(burst_idx)
  );

  // PRBS7 (x^7 + x^6 + 1) core: the output bit is the feedback bit.
  always @(posedge clk) begin
    if (prbs_load) begin
      core <= prbs_seed;
    end else if (prbs_en) begin
      core     <= {core[5:0], core[6] ^ core[5]};
      prbs_bit <= core[6] ^ core[5];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One expected cycle of a running command.
  typedef struct {
    logic       load;
    logic       en;
    logic       done;
    logic [3:0] idx;
    logic       txbit;
    logic [6:0] seed;
  } rec_t;

  rec_t exp_q[$];

  // Expand an accepted command into its full expected cycle sequence.
  task automatic buildSchedule(input logic [6:0] seed, input logic [7:0] blen,
                               input logic [7:0] glen, input logic [3:0] rpt,
                               input logic einj, input logic [7:0] epos);
    rec_t       r;
    logic [6:0] s;
    logic       fb;
    int         total;
    s = (seed == 7'h00) ? 7'h01 : seed;
    r = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b0, s};
    exp_q.push_back(r);
    total = (blen == 8'h00) ? 256 : int'(blen);
    for (int b = 0; b <= int'(rpt); b++) begin
      for (int i = 0; i < total; i++) begin
        fb = s[6] ^ s[5];
        s  = {s[5:0], fb};
        r  = '{1'b0, 1'b1, 1'b0, 4'(b), fb ^ (einj && b == 0 && i == int'(epos)), 7'h00};
        exp_q.push_back(r);
      end
      if (b < int'(rpt)) begin
        for (int g = 0; g < int'(glen); g++) begin
          r = '{1'b0, 1'b0, 1'b0, 4'(b + 1), 1'b0, 7'h00};
          exp_q.push_back(r);
        end
      end
    end
    r = '{1'b0, 1'b0, 1'b1, rpt, 1'b0, 7'h00};
    exp_q.push_back(r);
  endtask

  logic prev_en = 1'b0;
  logic prev_bit = 1'b0;
  logic exp_ab = 1'b0;
  rec_t cur;
  logic have;
  logic model_einj;
  logic [7:0] model_epos;

  // Per-cycle compare against the schedule model (sampled on the falling edge).
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        prev_en  = 1'b0;
        prev_bit = 1'b0;
        exp_ab   = 1'b0;
      end else begin
        have = (exp_q.size() > 0);
        if (have) cur = exp_q.pop_front();
        else      cur = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 7'h00};
        checkOutput("cmd_ready", 32'(cmd_ready), 32'(!have));
        checkOutput("busy",      32'(busy),      32'(have));
        checkOutput("prbs_load", 32'(prbs_load), 32'(cur.load));
        checkOutput("prbs_en",   32'(prbs_en),   32'(cur.en));
        checkOutput("done",      32'(done),      32'(cur.done));
        checkOutput("aborted",   32'(aborted),   32'(exp_ab));
        checkOutput("tx_valid",  32'(tx_valid),  32'(prev_en));
        checkOutput("tx_bit",    32'(tx_bit),    32'(prev_en & prev_bit));
        if (have) checkOutput("burst_idx", 32'(burst_idx), 32'(cur.idx));
        if (cur.load) checkOutput("prbs_seed", 32'(prbs_seed), 32'(cur.seed));
        prev_en  = cur.en;
        prev_bit = cur.txbit;
        exp_ab   = 1'b0;
        if (!have && cmd_valid) begin
`ifdef PRBS_ERR_INJECT_EN
          model_einj = err_inject;
          model_epos = err_pos;
`else
          model_einj = 1'b0;
          model_epos = 8'h00;
`endif
          buildSchedule(cmd_seed, cmd_burst_len, cmd_gap_len, cmd_repeat,
                        model_einj, model_epos);
        end else if (have && !cur.done && abort) begin
          exp_q.delete();
          exp_ab = 1'b1;
        end
      end
    end
  end

  int          en_count = 0, load_count = 0, done_count = 0, ab_count = 0;
  int          tx_count = 0, run_len = 0, max_run = 0;
  logic [63:0] tx_log = '0;
  logic [15:0] idx_mask = '0;

  // Activity counters and captured tx bit stream for the directed checks.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (prbs_en)   en_count++;
        if (prbs_load) load_count++;
        if (done)      done_count++;
        if (aborted)   ab_count++;
        if (tx_valid) begin
          tx_count++;
          tx_log = {tx_log[62:0], tx_bit};
        end
        if (prbs_en) begin
          run_len++;
          idx_mask[burst_idx] = 1'b1;
        end else begin
          run_len = 0;
        end
        if (run_len > max_run) max_run = run_len;
      end
    end
  end

  int s_en, s_load, s_done, s_ab, s_tx;

  task automatic snap();
    s_en = en_count; s_load = load_count; s_done = done_count;
    s_ab = ab_count; s_tx = tx_count;
  endtask

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle(input int max);
    int k = 0;
    while (busy && k < max) begin
      waitCycle();
      k++;
    end
    if (busy) checkOutput("idle_timeout", 32'd1, 32'd0);
  endtask

  // Present one command, then scramble the fields to show they were latched.
  task automatic applyStimulus(input logic [6:0] seed, input logic [7:0] blen,
                               input logic [7:0] glen, input logic [3:0] rpt);
    cmd_seed = seed; cmd_burst_len = blen; cmd_gap_len = glen; cmd_repeat = rpt;
    cmd_valid = 1'b1;
    waitCycle();
    cmd_valid = 1'b0;
    cmd_seed = 7'h33; cmd_burst_len = 8'hEE; cmd_gap_len = 8'h77; cmd_repeat = 4'hF;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    $display("[TB] start");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rst_busy",      32'(busy),      32'd0);
    checkOutput("rst_seed",      32'(prbs_seed), 32'd1);
    checkOutput("rst_load",      32'(prbs_load), 32'd0);
    checkOutput("rst_en",        32'(prbs_en),   32'd0);
    checkOutput("rst_tx_valid",  32'(tx_valid),  32'd0);
    checkOutput("rst_tx_bit",    32'(tx_bit),    32'd0);
    checkOutput("rst_done",      32'(done),      32'd0);
    checkOutput("rst_aborted",   32'(aborted),   32'd0);
    checkOutput("rst_burst_idx", 32'(burst_idx), 32'd0);
    rst = 1'b0;
    waitCycle();

    $display("[TB] two bursts with gap");
    snap();
    applyStimulus(7'h5A, 8'd5, 8'd3, 4'd1);
    waitIdle(100);
    waitCycle();
    checkOutput("t1_en_cycles",  32'(en_count - s_en),     32'd10);
    checkOutput("t1_tx_cycles",  32'(tx_count - s_tx),     32'd10);
    checkOutput("t1_loads",      32'(load_count - s_load), 32'd1);
    checkOutput("t1_dones",      32'(done_count - s_done), 32'd1);
    checkOutput("t1_tx_bits",    32'(tx_log[9:0]),         32'b1101111011);

    $display("[TB] zero seed");
    snap();
    applyStimulus(7'h00, 8'd4, 8'd2, 4'd0);
    waitIdle(100);
    waitCycle();
    checkOutput("t2_en_cycles", 32'(en_count - s_en),     32'd4);
    checkOutput("t2_dones",     32'(done_count - s_done), 32'd1);
    checkOutput("t2_seed",      32'(prbs_seed),           32'd1);

    $display("[TB] back-to-back bursts");
    snap();
    applyStimulus(7'h11, 8'd3, 8'd0, 4'd2);
    waitIdle(100);
    waitCycle();
    checkOutput("t3_en_cycles", 32'(en_count - s_en), 32'd9);
    checkOutput("t3_max_run",   32'(max_run),         32'd9);
    checkOutput("t3_idx_seen",  32'(idx_mask),        32'h0007);

    $display("[TB] command held off while busy");
    snap();
    cmd_seed = 7'h23; cmd_burst_len = 8'd4; cmd_gap_len = 8'd2; cmd_repeat = 4'd1;
    cmd_valid = 1'b1;
    waitCycle();
    cmd_seed = 7'h44; cmd_burst_len = 8'd3; cmd_gap_len = 8'd1; cmd_repeat = 4'd0;
    checkOutput("t4_ready_low", 32'(cmd_ready), 32'd0);
    k = 0;
    while (!cmd_ready && k < 100) begin
      waitCycle();
      k++;
    end
    if (!cmd_ready) checkOutput("t4_ready_timeout", 32'd1, 32'd0);
    waitCycle();
    cmd_valid = 1'b0;
    checkOutput("t4_second_load", 32'(prbs_load), 32'd1);
    waitIdle(100);
    waitCycle();
    checkOutput("t4_loads",     32'(load_count - s_load), 32'd2);
    checkOutput("t4_en_cycles", 32'(en_count - s_en),     32'd11);
    checkOutput("t4_dones",     32'(done_count - s_done), 32'd2);
    checkOutput("t4_seed",      32'(prbs_seed),           32'h44);

    $display("[TB] abort on third run cycle");
    snap();
    applyStimulus(7'h3C, 8'd10, 8'd0, 4'd0);
    k = 0;
    while (!prbs_en && k < 10) begin
      waitCycle();
      k++;
    end
    if (!prbs_en) checkOutput("t5_run_timeout", 32'd1, 32'd0);
    waitCycle();
    waitCycle();
    abort = 1'b1;
    waitCycle();
    abort = 1'b0;
    checkOutput("t5_en_off",    32'(prbs_en),  32'd0);
    checkOutput("t5_busy_off",  32'(busy),     32'd0);
    checkOutput("t5_aborted",   32'(aborted),  32'd1);
    checkOutput("t5_tx_tail",   32'(tx_valid), 32'd1);
    waitCycle();
    checkOutput("t5_aborted_end", 32'(aborted),  32'd0);
    checkOutput("t5_tx_end",      32'(tx_valid), 32'd0);
    checkOutput("t5_en_cycles",   32'(en_count - s_en),     32'd3);
    checkOutput("t5_dones",       32'(done_count - s_done), 32'd0);
    checkOutput("t5_abort_count", 32'(ab_count - s_ab),     32'd1);

    $display("[TB] abort while idle");
    snap();
    abort = 1'b1;
    waitCycle();
    waitCycle();
    abort = 1'b0;
    waitCycle();
    checkOutput("t6_abort_count", 32'(ab_count - s_ab), 32'd0);

    $display("[TB] abort during done");
    snap();
    applyStimulus(7'h09, 8'd2, 8'd0, 4'd0);
    k = 0;
    while (!done && k < 20) begin
      waitCycle();
      k++;
    end
    if (!done) checkOutput("t7_done_timeout", 32'd1, 32'd0);
    abort = 1'b1;
    waitCycle();
    abort = 1'b0;
    checkOutput("t7_aborted", 32'(aborted), 32'd0);
    waitCycle();
    checkOutput("t7_dones",       32'(done_count - s_done), 32'd1);
    checkOutput("t7_abort_count", 32'(ab_count - s_ab),     32'd0);

    $display("[TB] full-length burst");
    snap();
    applyStimulus(7'h7F, 8'd0, 8'd5, 4'd0);
    waitIdle(400);
    waitCycle();
    checkOutput("t8_en_cycles", 32'(en_count - s_en),     32'd256);
    checkOutput("t8_dones",     32'(done_count - s_done), 32'd1);

    $display("[TB] reset mid-command");
    snap();
    applyStimulus(7'h15, 8'd20, 8'd0, 4'd0);
    repeat (5) waitCycle();
    rst = 1'b1;
    #1;
    checkOutput("t9_busy",      32'(busy),      32'd0);
    checkOutput("t9_en",        32'(prbs_en),   32'd0);
    checkOutput("t9_seed",      32'(prbs_seed), 32'd1);
    checkOutput("t9_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("t9_tx_valid",  32'(tx_valid),  32'd0);
    waitCycle();
    rst = 1'b0;
    waitCycle();
    waitCycle();
    checkOutput("t9_dones",       32'(done_count - s_done), 32'd0);
    checkOutput("t9_abort_count", 32'(ab_count - s_ab),     32'd0);

`ifdef PRBS_ERR_INJECT_EN
    $display("[TB] error injection");
    snap();
    err_inject = 1'b1;
    err_pos = 8'd2;
    applyStimulus(7'h5A, 8'd6, 8'd0, 4'd1);
    err_inject = 1'b0;
    err_pos = 8'd0;
    waitIdle(100);
    waitCycle();
    checkOutput("t10_tx_cycles", 32'(tx_count - s_tx), 32'd12);
    checkOutput("t10_tx_bits",   32'(tx_log[11:0]),    32'b111111101100);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prbs_burst_ctrl.md
Name: prbs_burst_ctrl

Overview:
Sequencer for the PRBS generator datapath. It accepts a burst command over a valid/ready handshake, seeds the LFSR core once, and then steps it for a programmed number of bits per burst. Bursts are separated by programmed idle gaps and repeated a programmed number of times. It sits between the pin-level register/IO logic of the top-level and the LFSR core, driving the core's load and enable strobes.

Parameters:
SEED_W, 7, LFSR width / seed width (PRBS7 default)
LEN_W, 8, width of burst-length and gap-length fields
RPT_W, 4, width of repeat-count field

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command
cmd_seed  input  SEED_W  LFSR seed for this command
cmd_burst_len  input  LEN_W  bits per burst; 0 means 2^LEN_W
cmd_gap_len  input  LEN_W  idle cycles between bursts; 0 means no gap
cmd_repeat  input  RPT_W  extra bursts after the first (total = cmd_repeat+1)
abort  input  1  terminate current command
prbs_load  output  1  one-cycle strobe: core loads prbs_seed
prbs_seed  output  SEED_W  seed to core, nonzero guaranteed
prbs_en  output  1  core advances one bit this cycle
prbs_bit  input  1  core serial output (valid the cycle after prbs_en)
tx_bit  output  1  gated serial bit to pins
tx_valid  output  1  tx_bit is a live PRBS bit
busy  output  1  command in progress (not IDLE)
done  output  1  one-cycle pulse on normal completion
aborted  output  1  one-cycle pulse when abort took effect
burst_idx  output  RPT_W  index of current burst, 0-based

Behaviour:
- Reset (rst=1, async): state IDLE; cmd_ready=1; prbs_load, prbs_en, tx_valid, tx_bit, busy, done, aborted = 0; prbs_seed = 1; burst_idx = 0; all counters 0.
- States: IDLE, LOAD, RUN, GAP, DONE.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch all cmd_* fields and go to LOAD. Fields are sampled only at acceptance; later changes are ignored.
- LOAD: prbs_load=1 for exactly one cycle. prbs_seed = latched seed, or 1 if the latched seed == 0. Next state RUN, bit counter cleared, burst_idx=0.
- RUN: prbs_en=1 every cycle for exactly burst_len cycles (2^LEN_W if 0).
  - On the last RUN cycle: if burst_idx == repeat, go to DONE.
  - Otherwise burst_idx increments and next state is GAP, or RUN directly if gap_len==0.
  - The seed is not reloaded between bursts; the sequence continues.
- GAP: prbs_en=0 for exactly gap_len cycles, then RUN.
- DONE: done=1 for one cycle, then IDLE; cmd_ready returns 1 in IDLE.
- busy = (state != IDLE). cmd_ready = (state == IDLE); commands presented while busy are held off, not dropped.
- tx_valid = prbs_en delayed one cycle. tx_bit = prbs_bit when tx_valid, else 0. Latency from prbs_en to tx_valid is 1 cycle.
- abort: sampled in any non-IDLE state.
  - Takes priority over every transition: next state IDLE, prbs_en=0 from the next cycle, aborted=1 for one cycle, done not asserted.
  - The in-flight tx_valid from the final prbs_en cycle still completes.
  - abort in IDLE is ignored (no pulse).
- abort and DONE in the same cycle: done is already asserted and the FSM is leaving, so abort is ignored.
- Counters wrap-safe: bit and gap counters are LEN_W+1 bits wide so 2^LEN_W is reachable without overflow.
- Reset mid-command: immediate return to reset values. No done or aborted pulse.

Optional Feature:
Macro PRBS_ERR_INJECT_EN.
- Defined: adds input err_inject (1) and input err_pos (LEN_W). When err_inject is high at command acceptance, tx_bit is inverted on the bit whose in-burst index equals err_pos, in burst 0 only. err_pos >= burst_len means no inversion. Ports exist only when defined.
- Undefined: no extra ports; tx_bit is always the unmodified prbs_bit.

Test Plan:
- Seed 7'h5A, burst_len 5, gap_len 3, repeat 1 -> LOAD 1 cycle, prbs_en high 5, low 3, high 5. done pulses one cycle after the last RUN cycle. tx_valid asserted 10 cycles total, each 1 cycle after prbs_en.
- Seed 0, burst_len 4, repeat 0 -> prbs_seed=1 during prbs_load. Exactly 4 prbs_en cycles, then done.
- gap_len 0, burst_len 3, repeat 2 -> prbs_en high 9 consecutive cycles. burst_idx steps 0,1,2.
- cmd_valid held high while busy with a second command -> cmd_ready=0 until after done. The second command is accepted in the first IDLE cycle with its own fields.
- abort asserted on the 3rd RUN cycle of burst_len 10 -> aborted pulses once, prbs_en low the next cycle, no done, busy=0 next cycle.
- With PRBS_ERR_INJECT_EN, err_inject=1, err_pos=2, burst_len 6, compared against a reference LFSR -> only tx bit index 2 of burst 0 differs.
